// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one async-read ROM port among NUM_REQ requesters; build option ROM_ARB_FIXED_PRIO_EN selects fixed priority.
// Latency: request seen -> grant+ROM read next cycle -> registered response the cycle after (2 cycles); one read per 2 cycles peak.
// Backpressure: response held stable until rsp_ready; no new arbitration while a response is pending.
module rom_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        grant,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic                      rom_ce,
    output logic                      rom_read_en,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id
);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t             state, state_nxt;
    logic               arb_en, arb_fire;
    logic               lo_found;
    logic [ID_W-1:0]    lo_idx, win_idx, cur_id;
    logic [ADDR_W-1:0]  win_addr;
`ifndef ROM_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]    last;
    logic [ID_W-1:0]    hi_idx;
    logic               hi_found;
`endif

    // lo_idx is the lowest requesting index; hi_idx the lowest one above the last winner.
    always_comb begin
        lo_idx   = '0;
        lo_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx   = ID_W'(i);
                lo_found = 1'b1;
            end
        end
`ifdef ROM_ARB_FIXED_PRIO_EN
        win_idx = lo_idx;
`else
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (ID_W'(i) > last)) begin
                hi_idx   = ID_W'(i);
                hi_found = 1'b1;
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
`endif
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win_idx) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        arb_en    = 1'b0;
        case (state)
            IDLE: begin
                arb_en = 1'b1;
                if (lo_found) state_nxt = READ;
            end
            READ: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    arb_en    = 1'b1;
                    state_nxt = lo_found ? READ : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        arb_fire = arb_en && lo_found;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant       <= '0;
            rom_addr    <= '0;
            rom_ce      <= 1'b0;
            rom_read_en <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_id      <= '0;
            cur_id      <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
            last        <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            grant       <= '0;
            rom_ce      <= 1'b0;
            rom_read_en <= 1'b0;
            if (arb_fire) begin
                grant       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                rom_addr    <= win_addr;
                rom_ce      <= 1'b1;
                rom_read_en <= 1'b1;
                cur_id      <= win_idx;
`ifndef ROM_ARB_FIXED_PRIO_EN
                last        <= win_idx;
`endif
            end
            if (state == READ) begin
                rsp_data  <= rom_data;
                rsp_id    <= cur_id;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
